// File: rtl/synth_bus_pkg.sv
// rtl/synth_bus_pkg.sv - shared synth register bus definitions for channel programming
package synth_bus_pkg;

  localparam logic [15:0] REG_GATE       = 16'd0;
  localparam logic [15:0] REG_INCR       = 16'd1;
  localparam logic [15:0] REG_WAVETYPE   = 16'd2;
  localparam logic [15:0] REG_PULSEWIDTH = 16'd3;
  localparam logic [15:0] REG_SUSTAIN    = 16'd4;
  localparam logic [15:0] REG_LINEAR     = 16'd5;
  localparam logic [15:0] REG_ADSRSTATE  = 16'd6;

  localparam int DEFAULT_CHAN_STRIDE = 8;

  localparam logic [7:0] GATE_OFF_DATA = 8'h00;
  localparam logic [7:0] GATE_ON_DATA  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WSET = 2'd1,
    ST_WCLK = 2'd2
  } bus_state_e;

  // A write plan is a contiguous run of these steps; free note-ons skip the
  // leading gate-off, note-offs stop after it.
  typedef enum logic [1:0] {
    STEP_GATE_OFF = 2'd0,
    STEP_INCR     = 2'd1,
    STEP_GATE_ON  = 2'd2
  } write_step_e;

endpackage

// File: rtl/voice_picker.sv
// rtl/voice_picker.sv - combinational voice selection: key match, lowest free voice, victim
module voice_picker #(
  parameter int NUM_CHANNELS = 4,
  parameter int IDX_W        = 2
) (
  input  logic [NUM_CHANNELS-1:0]   busy_i,
  input  logic [NUM_CHANNELS*7-1:0] keys_i,
  input  logic [6:0]                key_i,
  input  logic [IDX_W-1:0]          steal_ptr_i,
  output logic                      match_hit_o,
  output logic [IDX_W-1:0]          match_idx_o,
  output logic                      free_hit_o,
  output logic [IDX_W-1:0]          free_idx_o,
  output logic [IDX_W-1:0]          pick_idx_o
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    match_hit_o = 1'b0;
    match_idx_o = '0;
    free_hit_o  = 1'b0;
    free_idx_o  = '0;
    for (int v = NUM_CHANNELS - 1; v >= 0; v--) begin
      if (busy_i[v] && (keys_i[v*7 +: 7] == key_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = IDX_W'(v);
      end
      if (!busy_i[v]) begin
        free_hit_o = 1'b1;
        free_idx_o = IDX_W'(v);
      end
    end
  end

  always_comb begin
    if (match_hit_o) begin
      pick_idx_o = match_idx_o;
    end else if (free_hit_o) begin
      pick_idx_o = free_idx_o;
    end else begin
      pick_idx_o = steal_ptr_i;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator and synth register bus master
module voice_allocator
  import synth_bus_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          CHAN_STRIDE  = DEFAULT_CHAN_STRIDE
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    NoteValid,
  input  logic                    NoteOn,
  input  logic [6:0]              NoteKey,
  input  logic [7:0]              NoteIncr,
  output logic                    NoteReady,
  output logic [15:0]             BusAddress,
  output logic [7:0]              BusDataOut,
  output logic                    BusWrite,
  output logic                    BusClock,
  output logic [NUM_CHANNELS-1:0] VoiceBusy
);

  localparam int              IDX_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_VOICE = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [15:0]     STRIDE16   = 16'(CHAN_STRIDE);

  bus_state_e                state_q, state_d;
  write_step_e               step_q, step_d;
  logic [NUM_CHANNELS-1:0]   busy_q, busy_d;
  logic [NUM_CHANNELS*7-1:0] keys_q, keys_d;
  logic [IDX_W-1:0]          steal_q, steal_d;
  logic [IDX_W-1:0]          voice_q, voice_d;
  logic [7:0]                incr_q, incr_d;
  logic                      off_q, off_d;

  logic             match_hit, free_hit;
  logic [IDX_W-1:0] match_idx, free_idx, pick_idx;
  logic             accept, last_write;

  voice_picker #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .busy_i     (busy_q),
    .keys_i     (keys_q),
    .key_i      (NoteKey),
    .steal_ptr_i(steal_q),
    .match_hit_o(match_hit),
    .match_idx_o(match_idx),
    .free_hit_o (free_hit),
    .free_idx_o (free_idx),
    .pick_idx_o (pick_idx)
  );

  assign NoteReady  = Reset && (state_q == ST_IDLE);
  assign accept     = NoteValid && NoteReady;
  assign last_write = off_q || (step_q == STEP_GATE_ON);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    busy_d  = busy_q;
    keys_d  = keys_q;
    steal_d = steal_q;
    voice_d = voice_q;
    incr_d  = incr_q;
    off_d   = off_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && NoteOn) begin
          state_d = ST_WSET;
          voice_d = pick_idx;
          incr_d  = NoteIncr;
          off_d   = 1'b0;
          step_d  = (!match_hit && free_hit) ? STEP_INCR : STEP_GATE_OFF;
          if (!match_hit && !free_hit) begin
            steal_d = (steal_q == LAST_VOICE) ? '0 : steal_q + IDX_W'(1);
          end
          busy_d[pick_idx]              = 1'b1;
          keys_d[int'(pick_idx)*7 +: 7] = NoteKey;
        end else if (accept && match_hit) begin
          state_d = ST_WSET;
          voice_d = match_idx;
          off_d   = 1'b1;
          step_d  = STEP_GATE_OFF;
        end
      end
      ST_WSET: state_d = ST_WCLK;
      ST_WCLK: begin
        if (last_write) begin
          state_d = ST_IDLE;
          if (off_q) begin
            busy_d[voice_q] = 1'b0;
          end
        end else begin
          state_d = ST_WSET;
          step_d  = (step_q == STEP_GATE_OFF) ? STEP_INCR : STEP_GATE_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_GATE_OFF;
      busy_q  <= '0;
      keys_q  <= '0;
      steal_q <= '0;
      voice_q <= '0;
      incr_q  <= '0;
      off_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      keys_q  <= keys_d;
      steal_q <= steal_d;
      voice_q <= voice_d;
      incr_q  <= incr_d;
      off_q   <= off_d;
    end
  end

  // Bus outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    BusAddress = '0;
    BusDataOut = '0;
    if (state_q != ST_IDLE) begin
      BusAddress = BASE_ADDR + 16'(voice_q) * STRIDE16
                 + ((step_q == STEP_INCR) ? REG_INCR : REG_GATE);
      unique case (step_q)
        STEP_INCR:    BusDataOut = incr_q;
        STEP_GATE_ON: BusDataOut = GATE_ON_DATA;
        default:      BusDataOut = GATE_OFF_DATA;
      endcase
    end
  end

  assign BusWrite  = (state_q != ST_IDLE);
  assign BusClock  = (state_q == ST_WCLK);
  assign VoiceBusy = busy_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        note_valid, note_on;
  logic [6:0]  note_key;
  logic [7:0]  note_incr;
  logic        note_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_write, bus_clock;
  logic [3:0]  voice_busy;

  int tests = 0;
  int fails = 0;
  logic [23:0] wq[$];
  logic [23:0] setup_val;

  voice_allocator dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .NoteValid (note_valid),
    .NoteOn    (note_on),
    .NoteKey   (note_key),
    .NoteIncr  (note_incr),
    .NoteReady (note_ready),
    .BusAddress(bus_addr),
    .BusDataOut(bus_data),
    .BusWrite  (bus_write),
    .BusClock  (bus_clock),
    .VoiceBusy (voice_busy)
  );

  always #5 clk = ~clk;

  // Record every completed write and confirm address/data held steady through it.
  always @(negedge clk) begin
    if (bus_write && !bus_clock) setup_val = {bus_addr, bus_data};
    if (bus_clock) begin
      wq.push_back({bus_addr, bus_data});
      tests++;
      if (!bus_write || {bus_addr, bus_data} !== setup_val) begin
        fails++;
        $display("FAIL bus_stable got %h want %h write=%b", {bus_addr, bus_data}, setup_val, bus_write);
      end
    end
  end

  task automatic send_note(input logic on, input logic [6:0] key, input logic [7:0] incr,
                           output int busy_cycles);
    bit done = 0;
    int n = 0;
    wq.delete();
    tests++;
    if (note_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_accept got %b want 1", note_ready);
    end
    note_valid = 1'b1; note_on = on; note_key = key; note_incr = incr;
    @(posedge clk); #1;
    note_valid = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (note_ready) done = 1; else n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL ready_timeout key %0d got busy>=%0d want ready", key, n);
    end
    busy_cycles = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; note_valid = 1'b0; note_on = 1'b0; note_key = '0; note_incr = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({note_ready, bus_addr, bus_data, bus_write, bus_clock, voice_busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b a=%h d=%h w=%b c=%b vb=%b want all 0",
               note_ready, bus_addr, bus_data, bus_write, bus_clock, voice_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (note_ready !== 1'b1 || bus_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got rdy=%b w=%b want rdy=1 w=0", note_ready, bus_write);
    end
  endtask

  task automatic test_free_note_on();
    int n;
    send_note(1'b1, 7'd60, 8'h20, n);
    tests++;
    if (wq.size() != 2 || wq[0] !== 24'h0001_20 || wq[1] !== 24'h0000_01) begin
      fails++;
      $display("FAIL free_writes got n=%0d %h %h want 2 000120 000001", wq.size(), wq[0], wq[1]);
    end
    tests++;
    if (n != 4 || voice_busy !== 4'b0001) begin
      fails++;
      $display("FAIL free_timing got busy_cycles=%0d vb=%b want 4 0001", n, voice_busy);
    end
  endtask

  task automatic test_fill_and_steal();
    int n;
    for (int v = 1; v < 4; v++) begin
      logic [15:0] ga;
      logic [7:0]  inc;
      ga  = 16'(v * 8);
      inc = 8'(8'h20 + v);
      send_note(1'b1, 7'(60 + v), inc, n);
      tests++;
      if (n != 4 || wq.size() != 2 || wq[0] !== {ga + 16'd1, inc} || wq[1] !== {ga, 8'h01}) begin
        fails++;
        $display("FAIL fill_v%0d got n=%0d cnt=%0d %h %h want 4 2 %h %h", v, n, wq.size(),
                 wq[0], wq[1], {ga + 16'd1, inc}, {ga, 8'h01});
      end
    end
    tests++;
    if (voice_busy !== 4'b1111) begin
      fails++;
      $display("FAIL fill_busy got %b want 1111", voice_busy);
    end
    send_note(1'b1, 7'd64, 8'h24, n);
    tests++;
    if (n != 6 || wq.size() != 3 || wq[0] !== 24'h0000_00 || wq[1] !== 24'h0001_24 || wq[2] !== 24'h0000_01) begin
      fails++;
      $display("FAIL steal_v0 got n=%0d cnt=%0d %h %h %h want 6 3 000000 000124 000001",
               n, wq.size(), wq[0], wq[1], wq[2]);
    end
    send_note(1'b1, 7'd65, 8'h25, n);
    tests++;
    if (n != 6 || wq.size() != 3 || wq[0] !== 24'h0008_00 || wq[1] !== 24'h0009_25 || wq[2] !== 24'h0008_01) begin
      fails++;
      $display("FAIL steal_v1 got n=%0d cnt=%0d %h %h %h want 6 3 000800 000925 000801",
               n, wq.size(), wq[0], wq[1], wq[2]);
    end
  endtask

  task automatic test_note_off();
    int n;
    send_note(1'b0, 7'd62, 8'h00, n);
    tests++;
    if (n != 2 || wq.size() != 1 || wq[0] !== 24'h0010_00 || voice_busy !== 4'b1011) begin
      fails++;
      $display("FAIL off_match got n=%0d cnt=%0d %h vb=%b want 2 1 001000 1011", n, wq.size(), wq[0], voice_busy);
    end
    send_note(1'b0, 7'd99, 8'h00, n);
    tests++;
    if (n != 0 || wq.size() != 0 || voice_busy !== 4'b1011) begin
      fails++;
      $display("FAIL off_unmatched got n=%0d cnt=%0d vb=%b want 0 0 1011", n, wq.size(), voice_busy);
    end
  endtask

  task automatic test_retrigger();
    int n;
    send_note(1'b1, 7'd64, 8'h30, n);
    tests++;
    if (n != 6 || wq.size() != 3 || wq[0] !== 24'h0000_00 || wq[1] !== 24'h0001_30 ||
        wq[2] !== 24'h0000_01 || voice_busy !== 4'b1011) begin
      fails++;
      $display("FAIL retrigger got n=%0d cnt=%0d %h %h %h vb=%b want 6 3 000000 000130 000001 1011",
               n, wq.size(), wq[0], wq[1], wq[2], voice_busy);
    end
    send_note(1'b1, 7'd70, 8'h40, n);
    tests++;
    if (n != 4 || wq.size() != 2 || wq[0] !== 24'h0011_40 || wq[1] !== 24'h0010_01 || voice_busy !== 4'b1111) begin
      fails++;
      $display("FAIL refill_v2 got n=%0d cnt=%0d %h %h vb=%b want 4 2 001140 001001 1111",
               n, wq.size(), wq[0], wq[1], voice_busy);
    end
  endtask

  task automatic test_reset_mid_steal();
    int n;
    bit seen = 0;
    note_valid = 1'b1; note_on = 1'b1; note_key = 7'd71; note_incr = 8'h41;
    @(posedge clk); #1;
    note_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_clock) seen = 1;
    end
    tests++;
    if (!seen || bus_addr !== 16'h0010 || bus_data !== 8'h00) begin
      fails++;
      $display("FAIL steal_v2_wclk got seen=%0d a=%h d=%h want 1 0010 00", seen, bus_addr, bus_data);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({note_ready, bus_addr, bus_data, bus_write, bus_clock, voice_busy} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got rdy=%b a=%h d=%h w=%b c=%b vb=%b want all 0",
               note_ready, bus_addr, bus_data, bus_write, bus_clock, voice_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_note(1'b1, 7'd72, 8'h50, n);
    tests++;
    if (n != 4 || wq.size() != 2 || wq[0] !== 24'h0001_50 || wq[1] !== 24'h0000_01 || voice_busy !== 4'b0001) begin
      fails++;
      $display("FAIL post_reset_v0 got n=%0d cnt=%0d %h %h vb=%b want 4 2 000150 000001 0001",
               n, wq.size(), wq[0], wq[1], voice_busy);
    end
  endtask

  task automatic test_back_to_back_steal_ptr();
    int n;
    for (int v = 1; v < 4; v++) send_note(1'b1, 7'(72 + v), 8'(8'h50 + v), n);
    send_note(1'b1, 7'd76, 8'h56, n);
    tests++;
    if (n != 6 || wq.size() != 3 || wq[0] !== 24'h0000_00 || wq[1] !== 24'h0001_56 ||
        wq[2] !== 24'h0000_01 || voice_busy !== 4'b1111) begin
      fails++;
      $display("FAIL steal_ptr_reset got n=%0d cnt=%0d %h %h %h vb=%b want 6 3 000000 000156 000001 1111",
               n, wq.size(), wq[0], wq[1], wq[2], voice_busy);
    end
  endtask

  initial begin
    test_reset();
    test_free_note_on();
    test_fill_and_steal();
    test_note_off();
    test_retrigger();
    test_reset_mid_steal();
    test_back_to_back_steal_ptr();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
